dual_core_dmem_responder: RTL and testbench

Data-memory responder for the core-side data interface (memread/memwr/dmaddr/dout in, din out). It serves two processor cores from one shared word-addressed RAM. A round-robin arbiter grants one core at a time. A counter inserts a fixed access latency, and a one-cycle ready pulse completes each transaction. The block sits between the core pair and the shared data store in the multicore top level.

---
 rtl/dual_core_dmem_responder.sv | 138 +++++++++++++
 tb/tb_dual_core_dmem_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dual_core_dmem_responder.sv
// Two-core round-robin data-memory responder over one shared word RAM, with a fixed access latency.
// Optional macro DMEM_ADDR_CHECK_EN: out-of-range addresses are blocked and flagged on addr_err.
module dual_core_dmem_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memread0,
  input  logic              memwr0,
  input  logic [15:0]       dmaddr0,
  input  logic [DATA_W-1:0] dout0,
  output logic [DATA_W-1:0] din0,
  output logic              ready0,
  input  logic              memread1,
  input  logic              memwr1,
  input  logic [15:0]       dmaddr1,
  input  logic [DATA_W-1:0] dout1,
  output logic [DATA_W-1:0] din1,
  output logic              ready1,
  output logic              busy,
  output logic              addr_err
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  state_t              r_state;
  logic                r_rr;
  logic                r_id;
  logic                r_wr;
  logic                r_oob;
  logic [3:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_din0;
  logic [DATA_W-1:0]   r_din1;
  logic                r_ready0;
  logic                r_ready1;
  logic                r_addr_err;
  logic [DATA_W-1:0]   r_mem [0:(1<<ADDR_W)-1];

  logic                w_req0;
  logic                w_req1;
  logic                w_gnt_id;
  logic                w_gnt_wr;
  logic [ADDR_W-1:0]   w_gnt_addr;
  logic [DATA_W-1:0]   w_gnt_data;
  logic                w_gnt_oob;
  logic                w_access;
  logic                w_unused_hi;

  assign w_req0 = memread0 | memwr0;
  assign w_req1 = memread1 | memwr1;
  // Contention goes to r_rr; otherwise whichever core is asking (core 1 only if core 0 is idle).
  assign w_gnt_id   = (w_req0 & w_req1) ? r_rr : w_req1;
  assign w_gnt_wr   = w_gnt_id ? memwr1 : memwr0;
  assign w_gnt_addr = w_gnt_id ? dmaddr1[ADDR_W-1:0] : dmaddr0[ADDR_W-1:0];
  assign w_gnt_data = w_gnt_id ? dout1 : dout0;
  assign w_unused_hi = ^{dmaddr0[15:ADDR_W], dmaddr1[15:ADDR_W]};

`ifdef DMEM_ADDR_CHECK_EN
  assign w_gnt_oob = w_gnt_id ? (dmaddr1[15:ADDR_W] != '0) : (dmaddr0[15:ADDR_W] != '0);
`else
  assign w_gnt_oob = 1'b0;
`endif

  assign w_access = (r_state == S_BUSY) && (r_cnt == 4'd0);

  // RAM has no reset; an aborted transaction never reaches BUSY-with-zero-count here.
  always_ff @(posedge clk) begin
    if (w_access && r_wr && !r_oob) r_mem[r_addr] <= r_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rr       <= 1'b0;
      r_id       <= 1'b0;
      r_wr       <= 1'b0;
      r_oob      <= 1'b0;
      r_cnt      <= 4'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_din0     <= '0;
      r_din1     <= '0;
      r_ready0   <= 1'b0;
      r_ready1   <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_ready0   <= 1'b0;
      r_ready1   <= 1'b0;
      r_addr_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req0 | w_req1) begin
            r_id    <= w_gnt_id;
            r_wr    <= w_gnt_wr;
            r_oob   <= w_gnt_oob;
            r_addr  <= w_gnt_addr;
            r_wdata <= w_gnt_data;
            r_cnt   <= LAT_M1;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            if (!r_wr) begin
              if (r_id) r_din1 <= r_oob ? '0 : r_mem[r_addr];
              else      r_din0 <= r_oob ? '0 : r_mem[r_addr];
            end
            r_ready0   <= ~r_id;
            r_ready1   <= r_id;
            r_addr_err <= r_oob;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          r_rr    <= ~r_id;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign din0     = r_din0;
  assign din1     = r_din1;
  assign ready0   = r_ready0;
  assign ready1   = r_ready1;
  assign busy     = (r_state != S_IDLE);
  assign addr_err = r_addr_err;

endmodule

// File: tb/tb_dual_core_dmem_responder.sv
// Scoreboard bench: per-core expected-response queues filled at issue, drained by a ready monitor.
module tb_dual_core_dmem_responder;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memread0 = 1'b0, memwr0 = 1'b0, memread1 = 1'b0, memwr1 = 1'b0;
  logic [15:0] dmaddr0 = '0, dmaddr1 = '0, dout0 = '0, dout1 = '0;
  logic [15:0] din0, din1;
  logic        ready0, ready1, busy, addr_err;

  dual_core_dmem_responder #(.ADDR_W(8), .DATA_W(16), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .memread0(memread0), .memwr0(memwr0), .dmaddr0(dmaddr0), .dout0(dout0),
    .din0(din0), .ready0(ready0),
    .memread1(memread1), .memwr1(memwr1), .dmaddr1(dmaddr1), .dout1(dout1),
    .din1(din1), .ready1(ready1),
    .busy(busy), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct { bit rd; logic [15:0] data; bit err; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int   served_core[$];
  int   served_cyc[$];
  logic [15:0] din_exp0 = '0, din_exp1 = '0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc++;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Monitor: pops the served core's queue on each ready and checks both din against the model.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      din_exp0 = '0;
      din_exp1 = '0;
    end else if (ready0 || ready1) begin
      chk("ready_exclusive", {31'd0, ready0 & ready1}, 32'd0);
      if (ready0) begin
        if (q0.size() == 0) chk("unexpected_ready0", 32'd1, 32'd0);
        else begin
          e = q0.pop_front();
          if (e.rd) din_exp0 = e.data;
          chk("addr_err0", {31'd0, addr_err}, {31'd0, e.err});
        end
        served_core.push_back(0);
      end else begin
        if (q1.size() == 0) chk("unexpected_ready1", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          if (e.rd) din_exp1 = e.data;
          chk("addr_err1", {31'd0, addr_err}, {31'd0, e.err});
        end
        served_core.push_back(1);
      end
      served_cyc.push_back(cyc);
      chk("din0", {16'd0, din0}, {16'd0, din_exp0});
      chk("din1", {16'd0, din1}, {16'd0, din_exp1});
    end
  end

  task automatic txn(input int c, input bit rd, input bit wr, input logic [15:0] a,
                     input logic [15:0] d, input logic [15:0] exp_d, input bit exp_err,
                     input int exp_lat);
    exp_t e;
    int   n;
    bit   got;
    e.rd = rd & ~wr; e.data = exp_d; e.err = exp_err;
    if (c == 0) q0.push_back(e); else q1.push_back(e);
    @(negedge clk);
    if (c == 0) begin memread0 = rd; memwr0 = wr; dmaddr0 = a; dout0 = d; end
    else        begin memread1 = rd; memwr1 = wr; dmaddr1 = a; dout1 = d; end
    n = 0; got = 0;
    while (!got && n < 40) begin
      @(posedge clk); n++;
      @(negedge clk);
      got = (c == 0) ? ready0 : ready1;
    end
    if (!got) chk("ready_timeout", 32'd0, 32'd1);
    else if (exp_lat != 0) chk("latency", n, exp_lat);
    @(posedge clk); #1;
    if (c == 0) begin memread0 = 0; memwr0 = 0; end
    else        begin memread1 = 0; memwr1 = 0; end
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int n0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_din0", {16'd0, din0}, 32'd0);
    chk("rst_din1", {16'd0, din1}, 32'd0);
    chk("rst_outs", {28'd0, ready0, ready1, busy, addr_err}, 32'd0);

    // Write then read back on core 0.
    txn(0, 0, 1, 16'd3, 16'hA5A5, 16'h0000, 0, LAT + 1);
    txn(0, 1, 0, 16'd3, 16'h0000, 16'hA5A5, 0, LAT + 1);

    // Simultaneous requests just after reset: core 0 first, core 1 sees its write.
    do_reset();
    n0 = served_core.size();
    fork
      txn(0, 0, 1, 16'd5, 16'h1111, 16'h0000, 0, LAT + 1);
      txn(1, 1, 0, 16'd5, 16'h0000, 16'h1111, 0, 0);
    join
    chk("contend_first", served_core[n0], 32'd0);
    chk("contend_second", served_core[n0 + 1], 32'd1);

    // Continuous contention: 8 transactions alternate at one per LAT+2 cycles.
    n0 = served_core.size();
    fork
      begin
        txn(0, 0, 1, 16'd32, 16'h3000, 16'h0000, 0, 0);
        txn(0, 1, 0, 16'd32, 16'h0000, 16'h3000, 0, 0);
        txn(0, 0, 1, 16'd33, 16'h3001, 16'h0000, 0, 0);
        txn(0, 1, 0, 16'd33, 16'h0000, 16'h3001, 0, 0);
      end
      begin
        txn(1, 0, 1, 16'd48, 16'h4000, 16'h0000, 0, 0);
        txn(1, 1, 0, 16'd48, 16'h0000, 16'h4000, 0, 0);
        txn(1, 0, 1, 16'd49, 16'h4001, 16'h0000, 0, 0);
        txn(1, 1, 0, 16'd49, 16'h0000, 16'h4001, 0, 0);
      end
    join
    chk("stream_count", served_core.size() - n0, 32'd8);
    for (int i = 1; i < 8 && n0 + i < served_core.size(); i++) begin
      chk("alternate", {31'd0, served_core[n0 + i] != served_core[n0 + i - 1]}, 32'd1);
      chk("throughput", served_cyc[n0 + i] - served_cyc[n0 + i - 1], LAT + 2);
    end

    // Read and write both high is a write.
    txn(1, 1, 1, 16'd7, 16'h00FF, 16'h0000, 0, 0);
    txn(0, 1, 0, 16'd7, 16'h0000, 16'h00FF, 0, 0);

    // Reset one cycle before the access edge of a write aborts it.
    txn(0, 0, 1, 16'd9, 16'h1234, 16'h0000, 0, 0);
    @(negedge clk);
    memwr0 = 1'b1; dmaddr0 = 16'd9; dout0 = 16'hBEEF;
    @(posedge clk);
    @(negedge clk);
    chk("busy_in_txn", {31'd0, busy}, 32'd1);
    @(posedge clk); #2 rst_n = 1'b0; memwr0 = 1'b0;
    @(negedge clk);
    chk("abort_no_ready", {30'd0, ready0, ready1}, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_state", {29'd0, ready0, ready1, busy}, 32'd0);
    chk("abort_din0", {16'd0, din0}, 32'd0);
    txn(0, 1, 0, 16'd9, 16'h0000, 16'h1234, 0, LAT + 1);

    // Out-of-range address.
    txn(0, 0, 1, 16'd0, 16'h5A5A, 16'h0000, 0, 0);
`ifdef DMEM_ADDR_CHECK_EN
    txn(0, 1, 0, 16'h0100, 16'h0000, 16'h0000, 1, 0);
`else
    txn(0, 1, 0, 16'h0100, 16'h0000, 16'h5A5A, 0, 0);
`endif

    repeat (2) @(negedge clk);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
